// File: rtl/sync2async_src_pkg.sv
// Shared FSM encodings and timing constants for the sync-to-async source stage.
// SYNC2ASYNC_SRC_SETUP_EN adds the SETUP state and its hold constant.
package sync2async_src_pkg;

  localparam int SYNC_STG_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
`ifdef SYNC2ASYNC_SRC_SETUP_EN
    ST_SETUP    = 2'd3,
`endif
    ST_WAIT_ACK = 2'd2
  } state_e;

`ifdef SYNC2ASYNC_SRC_SETUP_EN
  localparam int SETUP_CYC = 2;
  localparam int SETUP_CW  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
`endif

endpackage

// File: rtl/sync2async_src_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push refused when full,
// pop ignored when empty, read data shows the head entry combinationally.
module sync_fifo #(
  parameter int BW_DATA    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_pop,
  output logic [BW_DATA-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [BW_DATA-1:0] mem_q [FIFO_DEPTH];
  logic               do_push;
  logic               do_pop;

  always_comb begin
    o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    o_empty  = (wr_ptr_q == rd_ptr_q);
    do_push  = i_push & ~o_full;
    do_pop   = i_pop & ~o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    o_data   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sync2async_src.sv
// Clocked source launching FIFO words as 2-phase bundled-data tokens.
// SYNC2ASYNC_SRC_SETUP_EN inserts a SETUP hold between pop and req toggle.
module sync2async_src
  import sync2async_src_pkg::*;
#(
  parameter int BW_DATA    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STG   = SYNC_STG_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [BW_DATA-1:0] i_in_data,
  output logic               o_out_req,
  input  logic               i_out_ack,
  output logic [BW_DATA-1:0] o_out_data,
  output logic               o_busy,
  output logic               o_err
);

`ifdef SYNC2ASYNC_SRC_SETUP_EN
  localparam state_e ST_POST_POP = ST_SETUP;
`else
  localparam state_e ST_POST_POP = ST_LAUNCH;
`endif

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [BW_DATA-1:0] data_q, data_d;
  logic               err_q, err_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic               ack_s;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [BW_DATA-1:0] fifo_data;
`ifdef SYNC2ASYNC_SRC_SETUP_EN
  logic [SETUP_CW-1:0] cnt_q, cnt_d;
`endif

  sync_fifo #(
    .BW_DATA    (BW_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_in_valid),
    .i_data  (i_in_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign ack_s = sync_q[SYNC_STG-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STG-2:0], i_out_ack};
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
`ifdef SYNC2ASYNC_SRC_SETUP_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // no token outstanding, so any ack movement is spurious
        if (ack_s != req_q) err_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_data;
          state_d  = ST_POST_POP;
        end
      end
      ST_LAUNCH: begin
        req_d   = ~req_q;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_q) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_data;
            state_d  = ST_POST_POP;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
`ifdef SYNC2ASYNC_SRC_SETUP_EN
      ST_SETUP: begin
        if (cnt_q == SETUP_CW'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_LAUNCH;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      sync_q  <= '0;
`ifdef SYNC2ASYNC_SRC_SETUP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
`ifdef SYNC2ASYNC_SRC_SETUP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_in_ready = ~fifo_full;
  assign o_out_req  = req_q;
  assign o_out_data = data_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
